spi_pkt_sequencer: RTL and testbench

APB master that streams a 64-bit packet to the SPI block's APB slave as eight byte transfers, MSB byte first. Per byte: CONFIG write, TX write, CMD write, then STATUS polling until the SPI transfer completes. When enabled, it also reads back each RX byte and assembles a 64-bit receive packet. It replaces software byte loops and sits between the system controller and the SPI APB slave.

---
 rtl/spi_seq_pkg.sv | 33 +++
 rtl/apb_master_port.sv | 101 ++++++++++
 rtl/spi_pkt_sequencer.sv | 223 ++++++++++++++++++++++
 tb/tb_spi_pkt_sequencer.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_seq_pkg.sv
// Shared constants and state encodings for the SPI packet sequencer and its APB port.
package spi_seq_pkg;

    localparam int unsigned PKT_W  = 64;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned ADDR_W = 16;

    localparam logic [5:0] CFG_OFS = 6'h00;
    localparam logic [5:0] TX_OFS  = 6'h04;
    localparam logic [5:0] CMD_OFS = 6'h0C;

    localparam logic [7:0]  CMD_START     = 8'h02;
    localparam int unsigned STAT_BUSY_BIT = 0;

    typedef enum logic [2:0] {
        IDLE,
        CFG,
        TX,
        CMD,
        GAP,
        STAT,
        RXRD,
        NEXT
    } seq_state_e;

    typedef enum logic [1:0] {
        AP_IDLE,
        AP_SETUP,
        AP_ACCESS,
        AP_ACK
    } apb_state_e;

endpackage

// File: rtl/apb_master_port.sv
// Single-transfer APB master: SETUP, ACCESS until PREADY, then one idle cycle flagged by ack.
module apb_master_port
    import spi_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        write,
    input  logic [15:0] addr,
    input  logic [7:0]  wdata,
    output logic        psel,
    output logic        penable,
    output logic        pwrite,
    output logic [15:0] paddr,
    output logic [7:0]  pwdata,
    input  logic [7:0]  prdata,
    input  logic        pready,
    output logic        ack,
    output logic [7:0]  rdata
);

    apb_state_e  st_q, st_d;
    logic        psel_q, psel_d;
    logic        penable_q, penable_d;
    logic        pwrite_q, pwrite_d;
    logic [15:0] paddr_q, paddr_d;
    logic [7:0]  pwdata_q, pwdata_d;
    logic        ack_q, ack_d;
    logic [7:0]  rdata_q, rdata_d;

    // A new request is accepted during the idle cycle so back-to-back transfers take 3 cycles.
    always_comb begin
        st_d      = st_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        pwrite_d  = pwrite_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        rdata_d   = rdata_q;
        ack_d     = 1'b0;
        unique case (st_q)
            AP_IDLE, AP_ACK: begin
                st_d = AP_IDLE;
                if (req) begin
                    st_d      = AP_SETUP;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    pwrite_d  = write;
                    paddr_d   = addr;
                    pwdata_d  = write ? wdata : 8'h00;
                end
            end
            AP_SETUP: begin
                st_d      = AP_ACCESS;
                penable_d = 1'b1;
            end
            AP_ACCESS: begin
                if (pready) begin
                    st_d      = AP_ACK;
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    pwrite_d  = 1'b0;
                    rdata_d   = prdata;
                    ack_d     = 1'b1;
                end
            end
            default: st_d = AP_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q      <= AP_IDLE;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= 16'h0000;
            pwdata_q  <= 8'h00;
            ack_q     <= 1'b0;
            rdata_q   <= 8'h00;
        end else begin
            st_q      <= st_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            ack_q     <= ack_d;
            rdata_q   <= rdata_d;
        end
    end

    assign psel    = psel_q;
    assign penable = penable_q;
    assign pwrite  = pwrite_q;
    assign paddr   = paddr_q;
    assign pwdata  = pwdata_q;
    assign ack     = ack_q;
    assign rdata   = rdata_q;

endmodule

// File: rtl/spi_pkt_sequencer.sv
// Streams a 64-bit packet MSB byte first to the SPI APB slave, polling STATUS per byte
// and optionally assembling the returned RX bytes.
module spi_pkt_sequencer
    import spi_seq_pkg::*;
#(
    parameter logic [9:0]  BASE_ADDR = 10'd1,
    parameter int unsigned POLL_GAP  = 8,
    parameter int unsigned POLL_MAX  = 1024
) (
    input  logic        i_PCLK,
    input  logic        i_PRESET,
    input  logic        i_start,
    input  logic [63:0] i_pkt,
    input  logic [1:0]  i_mode,
    input  logic [1:0]  i_slave,
    input  logic [1:0]  i_sck,
    input  logic        i_rx_en,
    output logic        o_PSEL,
    output logic        o_PENABLE,
    output logic        o_PWRITE,
    output logic [15:0] o_PADDR,
    output logic [7:0]  o_PWDATA,
    input  logic [7:0]  i_PRDATA,
    input  logic        i_PREADY,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err,
    output logic [2:0]  o_byte_idx,
    output logic [63:0] o_rx_pkt
);

    seq_state_e  state_q, state_d;
    logic [63:0] shift_q, shift_d;
    logic [63:0] rx_pkt_q, rx_pkt_d;
    logic [2:0]  idx_q, idx_d;
    logic [15:0] poll_q, poll_d;
    logic [7:0]  gap_q, gap_d;
    logic [5:0]  cfg_q, cfg_d;
    logic        rx_en_q, rx_en_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic        req_c;
    logic        req_wr_c;
    logic [5:0]  req_ofs_c;
    logic [7:0]  req_wdata_c;
    logic [16:0] poll_inc_c;
    logic        ack;
    logic [7:0]  rdata;

    assign poll_inc_c = 17'(poll_q) + 17'd1;

    // Requests are raised on the transition into each transfer state.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        rx_pkt_d    = rx_pkt_q;
        idx_d       = idx_q;
        poll_d      = poll_q;
        gap_d       = gap_q;
        cfg_d       = cfg_q;
        rx_en_d     = rx_en_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = err_q;
        req_c       = 1'b0;
        req_wr_c    = 1'b0;
        req_ofs_c   = CFG_OFS;
        req_wdata_c = 8'h00;
        unique case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d     = CFG;
                    shift_d     = i_pkt;
                    cfg_d       = {i_mode, i_slave, i_sck};
                    rx_en_d     = i_rx_en;
                    rx_pkt_d    = 64'h0;
                    idx_d       = 3'd0;
                    poll_d      = 16'h0000;
                    gap_d       = 8'h00;
                    err_d       = 1'b0;
                    busy_d      = 1'b1;
                    req_c       = 1'b1;
                    req_wr_c    = 1'b1;
                    req_ofs_c   = CFG_OFS;
                    req_wdata_c = {2'b00, i_mode, i_slave, i_sck};
                end
            end
            CFG: begin
                if (ack) begin
                    state_d     = TX;
                    req_c       = 1'b1;
                    req_wr_c    = 1'b1;
                    req_ofs_c   = TX_OFS;
                    req_wdata_c = shift_q[63:56];
                end
            end
            TX: begin
                if (ack) begin
                    state_d     = CMD;
                    req_c       = 1'b1;
                    req_wr_c    = 1'b1;
                    req_ofs_c   = CMD_OFS;
                    req_wdata_c = CMD_START;
                end
            end
            CMD: begin
                if (ack) begin
                    state_d = GAP;
                    gap_d   = 8'h00;
                end
            end
            GAP: begin
                gap_d = gap_q + 8'd1;
                if (gap_q == 8'(POLL_GAP - 1)) begin
                    state_d   = STAT;
                    gap_d     = 8'h00;
                    req_c     = 1'b1;
                    req_ofs_c = CFG_OFS;
                end
            end
            STAT: begin
                if (ack) begin
                    poll_d = poll_inc_c[15:0];
                    if (rdata[STAT_BUSY_BIT]) begin
                        if (poll_inc_c >= 17'(POLL_MAX)) begin
                            state_d = IDLE;
                            err_d   = 1'b1;
                            busy_d  = 1'b0;
                        end else begin
                            state_d = GAP;
                        end
                    end else if (rx_en_q) begin
                        state_d   = RXRD;
                        req_c     = 1'b1;
                        req_ofs_c = TX_OFS;
                    end else begin
                        state_d = NEXT;
                    end
                end
            end
            RXRD: begin
                if (ack) begin
                    for (int b = 0; b < 8; b++) begin
                        if (idx_q == 3'(b)) rx_pkt_d[63-8*b -: 8] = rdata;
                    end
                    state_d = NEXT;
                end
            end
            NEXT: begin
                if (idx_q == 3'd7) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    state_d     = CFG;
                    shift_d     = {shift_q[55:0], 8'h00};
                    idx_d       = idx_q + 3'd1;
                    poll_d      = 16'h0000;
                    req_c       = 1'b1;
                    req_wr_c    = 1'b1;
                    req_ofs_c   = CFG_OFS;
                    req_wdata_c = {2'b00, cfg_q};
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_PCLK or posedge i_PRESET) begin
        if (i_PRESET) begin
            state_q  <= IDLE;
            shift_q  <= 64'h0;
            rx_pkt_q <= 64'h0;
            idx_q    <= 3'd0;
            poll_q   <= 16'h0000;
            gap_q    <= 8'h00;
            cfg_q    <= 6'h00;
            rx_en_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            rx_pkt_q <= rx_pkt_d;
            idx_q    <= idx_d;
            poll_q   <= poll_d;
            gap_q    <= gap_d;
            cfg_q    <= cfg_d;
            rx_en_q  <= rx_en_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    apb_master_port u_apb (
        .clk     (i_PCLK),
        .rst     (i_PRESET),
        .req     (req_c),
        .write   (req_wr_c),
        .addr    ({BASE_ADDR, req_ofs_c}),
        .wdata   (req_wdata_c),
        .psel    (o_PSEL),
        .penable (o_PENABLE),
        .pwrite  (o_PWRITE),
        .paddr   (o_PADDR),
        .pwdata  (o_PWDATA),
        .prdata  (i_PRDATA),
        .pready  (i_PREADY),
        .ack     (ack),
        .rdata   (rdata)
    );

    assign o_busy     = busy_q;
    assign o_done     = done_q;
    assign o_err      = err_q;
    assign o_byte_idx = idx_q;
    assign o_rx_pkt   = rx_pkt_q;

endmodule

// File: tb/tb_spi_pkt_sequencer.sv
// Directed bench for spi_pkt_sequencer: APB slave model, write scoreboard and transfer-shape monitor.
module tb_spi_pkt_sequencer;
    import spi_seq_pkg::*;

    localparam int unsigned GAP  = 4;
    localparam int unsigned PMAX = 4;
    localparam logic [63:0] P1   = 64'h8123456789ABCD0F;

    typedef struct packed {
        logic [15:0] a;
        logic [7:0]  d;
    } wr_t;

    logic        clk    = 1'b0;
    logic        rst    = 1'b1;
    logic        start1 = 1'b0;
    logic        start2 = 1'b0;
    logic [63:0] pkt    = 64'h0;
    logic [1:0]  mode   = 2'b00;
    logic [1:0]  slave  = 2'b00;
    logic [1:0]  sck    = 2'b00;
    logic        rx_en  = 1'b0;
    logic        sel    = 1'b0;
    logic [7:0]  prdata;
    logic        pready;

    logic        d1_psel, d1_penable, d1_pwrite, d1_busy, d1_done, d1_err;
    logic [15:0] d1_paddr;
    logic [7:0]  d1_pwdata;
    logic [2:0]  d1_idx;
    logic [63:0] d1_rx;
    logic        d2_psel, d2_penable, d2_pwrite, d2_busy, d2_done, d2_err;
    logic [15:0] d2_paddr;
    logic [7:0]  d2_pwdata;
    logic [2:0]  d2_idx;
    logic [63:0] d2_rx;

    logic        m_psel, m_penable, m_pwrite, m_busy, m_done, m_err;
    logic [15:0] m_paddr;
    logic [7:0]  m_pwdata;
    logic [2:0]  m_idx;
    logic [63:0] m_rx;

    spi_pkt_sequencer #(.BASE_ADDR(10'd1), .POLL_GAP(GAP), .POLL_MAX(PMAX)) dut1 (
        .i_PCLK(clk), .i_PRESET(rst), .i_start(start1), .i_pkt(pkt), .i_mode(mode),
        .i_slave(slave), .i_sck(sck), .i_rx_en(rx_en), .o_PSEL(d1_psel),
        .o_PENABLE(d1_penable), .o_PWRITE(d1_pwrite), .o_PADDR(d1_paddr),
        .o_PWDATA(d1_pwdata), .i_PRDATA(prdata), .i_PREADY(pready), .o_busy(d1_busy),
        .o_done(d1_done), .o_err(d1_err), .o_byte_idx(d1_idx), .o_rx_pkt(d1_rx)
    );

    spi_pkt_sequencer #(.BASE_ADDR(10'h3), .POLL_GAP(GAP), .POLL_MAX(PMAX)) dut2 (
        .i_PCLK(clk), .i_PRESET(rst), .i_start(start2), .i_pkt(pkt), .i_mode(mode),
        .i_slave(slave), .i_sck(sck), .i_rx_en(rx_en), .o_PSEL(d2_psel),
        .o_PENABLE(d2_penable), .o_PWRITE(d2_pwrite), .o_PADDR(d2_paddr),
        .o_PWDATA(d2_pwdata), .i_PRDATA(prdata), .i_PREADY(pready), .o_busy(d2_busy),
        .o_done(d2_done), .o_err(d2_err), .o_byte_idx(d2_idx), .o_rx_pkt(d2_rx)
    );

    assign m_psel    = sel ? d2_psel    : d1_psel;
    assign m_penable = sel ? d2_penable : d1_penable;
    assign m_pwrite  = sel ? d2_pwrite  : d1_pwrite;
    assign m_paddr   = sel ? d2_paddr   : d1_paddr;
    assign m_pwdata  = sel ? d2_pwdata  : d1_pwdata;
    assign m_busy    = sel ? d2_busy    : d1_busy;
    assign m_done    = sel ? d2_done    : d1_done;
    assign m_err     = sel ? d2_err     : d1_err;
    assign m_idx     = sel ? d2_idx     : d1_idx;
    assign m_rx      = sel ? d2_rx      : d1_rx;

    always #5 clk = ~clk;

    // SPI APB slave model: STATUS busy for a few reads after each CMD, RX returns ~TX.
    int         ws        = 0;
    bit         stuck     = 1'b0;
    int         busy_left = 0;
    int         wcnt      = 0;
    logic [7:0] last_tx   = 8'h00;

    assign pready = m_psel && m_penable && (wcnt == ws);
    assign prdata = (m_psel && !m_pwrite && m_paddr[5:0] == 6'h00) ? {7'd0, busy_left != 0} :
                    (m_psel && !m_pwrite && m_paddr[5:0] == 6'h04) ? ~last_tx : 8'h00;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt <= 0;
        end else if (m_psel && m_penable) begin
            if (wcnt == ws) begin
                wcnt <= 0;
                if (m_pwrite && m_paddr[5:0] == 6'h04) last_tx <= m_pwdata;
                if (m_pwrite && m_paddr[5:0] == 6'h0C) busy_left <= stuck ? 1 : 3;
                if (!m_pwrite && m_paddr[5:0] == 6'h00 && !stuck && busy_left > 0)
                    busy_left <= busy_left - 1;
            end else begin
                wcnt <= wcnt + 1;
            end
        end
    end

    int          total = 0;
    int          bad   = 0;
    int          done_cnt = 0, stat_reads = 0, rx_reads = 0, acc_cnt = 0;
    bit          stable = 1'b1, expect_idle = 1'b0;
    logic [15:0] s_addr = 16'h0, exp_base = 16'h0040;
    logic [7:0]  s_data = 8'h00;
    logic        s_wr = 1'b0;
    wr_t         exp_q[$];
    int          d0, s0, r0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock step; observes the bus mid-cycle and scores each completed transfer.
    task automatic tick();
        wr_t w;
        @(negedge clk);
        if (m_done) done_cnt++;
        if (expect_idle) begin
            chk("idle_cycle", 64'({m_psel, m_penable, m_pwrite}), 64'd0);
            expect_idle = 1'b0;
        end
        if (m_psel && !m_penable) begin
            s_addr = m_paddr;
            s_data = m_pwdata;
            s_wr   = m_pwrite;
            acc_cnt = 0;
            stable = 1'b1;
        end else if (m_psel && m_penable) begin
            acc_cnt++;
            if ({m_paddr, m_pwdata, m_pwrite} !== {s_addr, s_data, s_wr}) stable = 1'b0;
            if (pready) begin
                chk("stable", 64'(stable), 64'd1);
                chk("access_len", 64'(acc_cnt), 64'(ws + 1));
                expect_idle = 1'b1;
                if (m_pwrite) begin
                    chk("wr_pending", 64'(exp_q.size() > 0), 64'd1);
                    if (exp_q.size() > 0) begin
                        w = exp_q.pop_front();
                        chk("wr", 64'({m_paddr, m_pwdata}), 64'(w));
                    end
                end else begin
                    chk("rd_pwdata", 64'(m_pwdata), 64'd0);
                    chk("rd_addr", 64'(m_paddr == exp_base || m_paddr == exp_base + 16'h4), 64'd1);
                    if (m_paddr == exp_base) stat_reads++;
                    else if (m_paddr == exp_base + 16'h4) rx_reads++;
                end
            end
        end
    endtask

    task automatic push_pkt(input logic [63:0] p, input logic [7:0] cfg, input int nbytes);
        logic [63:0] sh;
        wr_t w;
        sh = p;
        for (int i = 0; i < nbytes; i++) begin
            w.a = exp_base;         w.d = cfg;         exp_q.push_back(w);
            w.a = exp_base + 16'h4; w.d = sh[63:56];   exp_q.push_back(w);
            w.a = exp_base + 16'hC; w.d = 8'h02;       exp_q.push_back(w);
            sh = {sh[55:0], 8'h00};
        end
    endtask

    task automatic go(input logic [63:0] p, input logic [1:0] md, input logic [1:0] sl,
                      input logic [1:0] sk, input logic rxe, input int nbytes);
        d0 = done_cnt; s0 = stat_reads; r0 = rx_reads;
        pkt = p; mode = md; slave = sl; sck = sk; rx_en = rxe;
        push_pkt(p, {2'b00, md, sl, sk}, nbytes);
        if (sel) start2 = 1'b1;
        else start1 = 1'b1;
        tick();
        start1 = 1'b0;
        start2 = 1'b0;
        chk("busy_after_start", 64'(m_busy), 64'd1);
    endtask

    task automatic wait_end(input bit want_done);
        int n = 0;
        while (m_busy && n < 20000) begin
            tick();
            n++;
        end
        chk("end_bounded", 64'(n < 20000), 64'd1);
        chk("done_at_fall", 64'(m_done), 64'(want_done));
        tick();
    endtask

    task automatic wait_byte(input logic [2:0] idx, input bit in_access);
        int n = 0;
        while (!(m_idx == idx && (!in_access || (m_psel && m_penable))) && n < 5000) begin
            tick();
            n++;
        end
        chk("reach_byte", 64'(n < 5000), 64'd1);
    endtask

    initial begin
        tick();
        tick();
        chk("rst_apb", 64'({d1_psel, d1_penable, d1_pwrite, d1_paddr, d1_pwdata}), 64'd0);
        chk("rst_stat", 64'({d1_busy, d1_done, d1_err, d1_idx}), 64'd0);
        chk("rst_rx", d1_rx, 64'd0);
        rst = 1'b0;
        tick();

        // Plain send, no readback
        go(P1, 2'b00, 2'b11, 2'b01, 1'b0, 8);
        wait_end(1'b1);
        chk("s1_err", 64'(m_err), 64'd0);
        chk("s1_done_cnt", 64'(done_cnt - d0), 64'd1);
        chk("s1_stat_reads", 64'(stat_reads - s0), 64'd32);
        chk("s1_rx_reads", 64'(rx_reads - r0), 64'd0);
        chk("s1_sb_empty", 64'(exp_q.size()), 64'd0);
        chk("s1_rx_pkt", m_rx, 64'd0);

        // Send with RX readback
        go(P1, 2'b00, 2'b11, 2'b01, 1'b1, 8);
        wait_end(1'b1);
        chk("s2_rx_pkt", m_rx, 64'h7EDCBA98765432F0);
        chk("s2_rx_reads", 64'(rx_reads - r0), 64'd8);
        chk("s2_stat_reads", 64'(stat_reads - s0), 64'd32);
        chk("s2_done_cnt", 64'(done_cnt - d0), 64'd1);
        chk("s2_sb_empty", 64'(exp_q.size()), 64'd0);

        // Two wait states on every ACCESS
        ws = 2;
        go(P1, 2'b00, 2'b11, 2'b01, 1'b0, 8);
        wait_end(1'b1);
        chk("s3_err", 64'(m_err), 64'd0);
        chk("s3_done_cnt", 64'(done_cnt - d0), 64'd1);
        chk("s3_sb_empty", 64'(exp_q.size()), 64'd0);
        ws = 0;

        // STATUS stuck busy: timeout on byte 0
        stuck = 1'b1;
        go(P1, 2'b00, 2'b11, 2'b01, 1'b0, 1);
        wait_end(1'b0);
        chk("s4_err", 64'(m_err), 64'd1);
        chk("s4_busy", 64'(m_busy), 64'd0);
        chk("s4_no_done", 64'(done_cnt - d0), 64'd0);
        chk("s4_idx", 64'(m_idx), 64'd0);
        chk("s4_stat_reads", 64'(stat_reads - s0), 64'(PMAX));
        chk("s4_sb_empty", 64'(exp_q.size()), 64'd0);
        stuck = 1'b0;

        // New start clears err; start during byte 3 is ignored
        go(P1, 2'b01, 2'b10, 2'b11, 1'b1, 8);
        chk("s5_err_clear", 64'(m_err), 64'd0);
        wait_byte(3'd3, 1'b0);
        pkt = 64'hFFFF_0000_FFFF_0000; mode = 2'b11; slave = 2'b00; sck = 2'b00; rx_en = 1'b0;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        wait_end(1'b1);
        chk("s5_rx_pkt", m_rx, 64'h7EDCBA98765432F0);
        chk("s5_done_cnt", 64'(done_cnt - d0), 64'd1);
        chk("s5_sb_empty", 64'(exp_q.size()), 64'd0);

        // Reset in the middle of a byte-5 ACCESS
        go(P1, 2'b00, 2'b11, 2'b01, 1'b1, 8);
        wait_byte(3'd5, 1'b1);
        #1 rst = 1'b1;
        #1;
        chk("s6_apb", 64'({d1_psel, d1_penable, d1_pwrite, d1_paddr, d1_pwdata}), 64'd0);
        chk("s6_stat", 64'({d1_busy, d1_done, d1_err, d1_idx}), 64'd0);
        chk("s6_rx", d1_rx, 64'd0);
        chk("s6_fsm", 64'(dut1.state_q), 64'(IDLE));
        tick();
        rst = 1'b0;
        exp_q.delete();
        tick();

        // BASE_ADDR = 3 instance
        sel = 1'b1;
        exp_base = 16'h00C0;
        go(P1, 2'b00, 2'b11, 2'b01, 1'b0, 8);
        wait_end(1'b1);
        chk("s7_done_cnt", 64'(done_cnt - d0), 64'd1);
        chk("s7_stat_reads", 64'(stat_reads - s0), 64'd32);
        chk("s7_sb_empty", 64'(exp_q.size()), 64'd0);
        chk("s7_err", 64'(m_err), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
